// File: rtl/pwm_gen.sv
// Center-less edge PWM with compare-value double buffering and ADC trigger.
// Optional dead-time insertion enabled by defining PWM_DEADTIME_EN.
module pwm_gen #(
  parameter logic [25:0] PERIOD     = 26'd1000,
  parameter logic [25:0] DEAD_TIME  = 26'd5,
  parameter logic [25:0] TRIG_POINT = 26'd500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [25:0] duty_in,
  input  logic        duty_valid,
  output logic        pwm_h,
  output logic        pwm_l,
  output logic        adc_trigger,
  output logic        period_start
);

  logic [25:0] cnt;
  logic [25:0] duty_act;
  logic [25:0] duty_pend;
  logic [25:0] duty_clamp;
  logic        last;
  logic        raw_h;
  logic        raw_l;

  always_comb begin
    duty_clamp = duty_in;
    if (duty_in > PERIOD)
      duty_clamp = PERIOD;
  end

  assign last  = (cnt == PERIOD - 26'd1);
  assign raw_h = enable && (cnt < duty_act);
  assign raw_l = enable && !(cnt < duty_act);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      duty_act     <= '0;
      duty_pend    <= '0;
      adc_trigger  <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (!enable || last)
        cnt <= '0;
      else
        cnt <= cnt + 26'd1;
      // a strobe landing on the wrap cycle bypasses the pending stage
      if (last)
        duty_act <= duty_valid ? duty_clamp : duty_pend;
      if (duty_valid)
        duty_pend <= duty_clamp;
      adc_trigger  <= enable && (cnt == TRIG_POINT);
      period_start <= enable && (cnt == 26'd0);
    end
  end

`ifdef PWM_DEADTIME_EN
  // run lengths of consecutive raw ones, saturating at DEAD_TIME
  logic [25:0] run_h;
  logic [25:0] run_l;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_h <= '0;
      run_l <= '0;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      if (!raw_h)
        run_h <= '0;
      else if (run_h != DEAD_TIME)
        run_h <= run_h + 26'd1;
      if (!raw_l)
        run_l <= '0;
      else if (run_l != DEAD_TIME)
        run_l <= run_l + 26'd1;
      pwm_h <= raw_h && (run_h == DEAD_TIME);
      pwm_l <= raw_l && (run_l == DEAD_TIME);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      pwm_h <= raw_h;
      pwm_l <= raw_l;
    end
  end
`endif

endmodule
